// File: rtl/frame_burst_writer_pkg.sv
// Shared definitions for the SDRAM write-side frame mover.
// State encodings stay as plain constants so legacy code can compare against them.
package frame_burst_writer_pkg;

    localparam int unsigned STATE_BITS = 3;

    localparam logic [STATE_BITS-1:0] S_IDLE      = 3'd0;
    localparam logic [STATE_BITS-1:0] S_ACK       = 3'd1;
    localparam logic [STATE_BITS-1:0] S_WAIT_FIFO = 3'd2;
    localparam logic [STATE_BITS-1:0] S_BURST     = 3'd3;
    localparam logic [STATE_BITS-1:0] S_BURST_END = 3'd4;

endpackage

// File: rtl/frame_burst_writer.sv
// Drains the producer FIFO into SDRAM as fixed-size write bursts until the
// requested frame length is stored; the last burst carries the remainder.
module frame_burst_writer
    import frame_burst_writer_pkg::*;
#(
    parameter int MEM_DATA_BITS   = 16,
    parameter int ADDR_BITS       = 24,
    parameter int BURST_BITS      = 10,
    parameter int BURST_SIZE      = 128,
    parameter int FIFO_COUNT_BITS = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       write_req,
    output logic                       write_req_ack,
    input  logic [ADDR_BITS-1:0]       write_addr,
    input  logic [ADDR_BITS-1:0]       write_len,
    output logic                       write_finish,
    output logic                       fifo_aclr,
    input  logic [FIFO_COUNT_BITS-1:0] fifo_rd_data_count,
    output logic                       fifo_rd_en,
    input  logic [MEM_DATA_BITS-1:0]   fifo_dout,
    output logic                       wr_burst_req,
    output logic [BURST_BITS-1:0]      wr_burst_len,
    output logic [ADDR_BITS-1:0]       wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0]   wr_burst_data,
    input  logic                       wr_burst_data_req,
    input  logic                       wr_burst_finish
);

    logic [STATE_BITS-1:0]  r_state;
    logic [ADDR_BITS-1:0]   r_cur_addr;
    logic [ADDR_BITS-1:0]   r_remaining;
    logic                   r_ack;
    logic                   r_finish;
    logic                   r_burst_req;
    logic [BURST_BITS-1:0]  r_burst_len;
    logic [ADDR_BITS-1:0]   r_burst_addr;

    logic [BURST_BITS-1:0]  w_this_len;
    logic                   w_fifo_ready;
    logic [ADDR_BITS-1:0]   w_next_remaining;
    logic [ADDR_BITS-1:0]   w_next_addr;

    always_comb begin
        w_this_len = BURST_BITS'(BURST_SIZE);
        if (r_remaining < ADDR_BITS'(BURST_SIZE))
            w_this_len = BURST_BITS'(r_remaining);
    end

    // Both sides zero-extended so FIFO and burst widths may differ freely.
    assign w_fifo_ready     = (32'(fifo_rd_data_count) >= 32'(w_this_len));
    assign w_next_remaining = r_remaining - ADDR_BITS'(r_burst_len);
    assign w_next_addr      = r_cur_addr + ADDR_BITS'(r_burst_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= '0;
            r_remaining  <= '0;
            r_ack        <= 1'b0;
            r_finish     <= 1'b0;
            r_burst_req  <= 1'b0;
            r_burst_len  <= '0;
            r_burst_addr <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (write_req) begin
                        r_cur_addr  <= write_addr;
                        r_remaining <= write_len;
                        r_ack       <= 1'b1;
                        r_state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!write_req) begin
                        r_ack <= 1'b0;
                        if (r_remaining != '0) begin
                            r_state <= S_WAIT_FIFO;
                        end else begin
                            r_finish <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                S_WAIT_FIFO: begin
                    if (w_fifo_ready) begin
                        r_burst_len  <= w_this_len;
                        r_burst_addr <= r_cur_addr;
                        r_burst_req  <= 1'b1;
                        r_state      <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (wr_burst_finish) begin
                        r_burst_req <= 1'b0;
                        r_state     <= S_BURST_END;
                    end
                end
                S_BURST_END: begin
                    r_cur_addr  <= w_next_addr;
                    r_remaining <= w_next_remaining;
                    if (w_next_remaining != '0) begin
                        r_state <= S_WAIT_FIFO;
                    end else begin
                        r_finish <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_ack       <= 1'b0;
                    r_burst_req <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign write_req_ack = r_ack;
    assign fifo_aclr     = r_ack;
    assign write_finish  = r_finish;
    assign wr_burst_req  = r_burst_req;
    assign wr_burst_len  = r_burst_len;
    assign wr_burst_addr = r_burst_addr;
    // FIFO reads are gated by state so a stray core request never drains it.
    assign fifo_rd_en    = wr_burst_data_req && (r_state == S_BURST);
    assign wr_burst_data = fifo_dout;

endmodule

// File: tb/tb_frame_burst_writer.sv
// Scoreboard bench for frame_burst_writer with a FIFO model and an SDRAM
// write-port model; expected bursts and data are queued as stimulus is driven.
module tb_frame_burst_writer;

    typedef struct packed {
        logic [23:0] addr;
        logic [9:0]  len;
    } burst_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_req = 1'b0;
    logic        write_req_ack;
    logic [23:0] write_addr = '0;
    logic [23:0] write_len = '0;
    logic        write_finish;
    logic        fifo_aclr;
    logic [9:0]  fifo_rd_data_count = '0;
    logic        fifo_rd_en;
    logic [15:0] fifo_dout = '0;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [23:0] wr_burst_addr;
    logic [15:0] wr_burst_data;
    logic        wr_burst_data_req = 1'b0;
    logic        wr_burst_finish = 1'b0;

    frame_burst_writer #(
        .MEM_DATA_BITS(16),
        .ADDR_BITS(24),
        .BURST_BITS(10),
        .BURST_SIZE(128),
        .FIFO_COUNT_BITS(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .write_req(write_req),
        .write_req_ack(write_req_ack),
        .write_addr(write_addr),
        .write_len(write_len),
        .write_finish(write_finish),
        .fifo_aclr(fifo_aclr),
        .fifo_rd_data_count(fifo_rd_data_count),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout),
        .wr_burst_req(wr_burst_req),
        .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr),
        .wr_burst_data(wr_burst_data),
        .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_finish(wr_burst_finish)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_data[$];
    burst_t      exp_burst[$];
    logic [15:0] pix = 16'h1000;

    int rd_cnt, rd_outside, finish_cnt, bursts_seen, burst_rd;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SDRAM write-port and FIFO model; shares rst_n with the DUT.
    initial begin : core_model
        int          phase = 0;
        int          left = 0;
        logic [9:0]  b_len = '0;
        logic [23:0] b_addr = '0;
        logic        s_req = 1'b0;
        logic        s_aclr = 1'b0;
        logic        pend_pop = 1'b0;
        logic        pend_chk = 1'b0;
        burst_t      e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_pop = 1'b0;
                pend_chk = 1'b0;
                s_req    = 1'b0;
                s_aclr   = 1'b0;
            end else begin
                if (pend_chk) begin
                    if (exp_data.size() != 0)
                        chk_val("burst_data", 32'(wr_burst_data), 32'(exp_data.pop_front()));
                    else
                        chk_val("data_extra", 32'(exp_data.size()), 32'd1);
                end
                pend_chk = 1'b0;
                if (fifo_rd_en) begin
                    rd_cnt++;
                    burst_rd++;
                    pend_pop = 1'b1;
                    if (!wr_burst_req) rd_outside++;
                end
                if (write_finish) finish_cnt++;
                s_req  = wr_burst_req;
                s_aclr = fifo_aclr;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                phase = 0;
                wr_burst_data_req = 1'b0;
                wr_burst_finish = 1'b0;
                fifo_dout = '0;
                continue;
            end
            if (s_aclr) fifo_q.delete();
            if (pend_pop) begin
                if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
                pend_pop = 1'b0;
                pend_chk = 1'b1;
            end
            fifo_rd_data_count = 10'(fifo_q.size());
            wr_burst_finish = 1'b0;
            case (phase)
                0: if (s_req) begin
                    b_len = wr_burst_len;
                    b_addr = wr_burst_addr;
                    left = int'(b_len);
                    burst_rd = 0;
                    bursts_seen++;
                    if (exp_burst.size() != 0) begin
                        e = exp_burst.pop_front();
                        chk_val("burst_addr", 32'(b_addr), 32'(e.addr));
                        chk_val("burst_len", 32'(b_len), 32'(e.len));
                    end else begin
                        chk_val("burst_unexpected", 32'(exp_burst.size()), 32'd1);
                    end
                    phase = 1;
                end
                1: if (left > 0) begin
                    wr_burst_data_req = 1'b1;
                    left--;
                end else begin
                    wr_burst_data_req = 1'b0;
                    phase = 2;
                end
                2: begin
                    chk_val("len_stable", 32'(wr_burst_len), 32'(b_len));
                    chk_val("addr_stable", 32'(wr_burst_addr), 32'(b_addr));
                    chk_val("rd_per_burst", 32'(burst_rd), 32'(b_len));
                    wr_burst_finish = 1'b1;
                    phase = 3;
                end
                default: phase = 0;
            endcase
        end
    end

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(pix);
            exp_data.push_back(pix);
            pix = pix + 16'h0013;
        end
        fifo_rd_data_count = 10'(fifo_q.size());
    endtask

    task automatic start_frame(input logic [23:0] addr, input logic [23:0] len);
        logic [23:0] a = addr;
        logic [23:0] rem = len;
        logic [23:0] c;
        int          waited = 0;
        rd_cnt = 0; rd_outside = 0; finish_cnt = 0; bursts_seen = 0;
        while (rem != 0) begin
            c = (rem < 24'd128) ? rem : 24'd128;
            exp_burst.push_back('{addr: a, len: 10'(c)});
            a = a + c;
            rem = rem - c;
        end
        @(posedge clk); #1;
        write_addr = addr;
        write_len  = len;
        write_req  = 1'b1;
        @(negedge clk);
        while (!write_req_ack && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk_val("ack_rise", 32'(write_req_ack), 32'd1);
        chk_val("aclr_with_ack", 32'(fifo_aclr), 32'd1);
        @(posedge clk); #1;
        write_req = 1'b0;
        write_addr = 24'h5A5A5A;
        write_len  = 24'h000123;
        @(negedge clk);
        chk_val("ack_hold", 32'(write_req_ack), 32'd1);
        @(negedge clk);
        chk_val("ack_fall", 32'(write_req_ack), 32'd0);
        chk_val("aclr_fall", 32'(fifo_aclr), 32'd0);
        chk_val("finish_at_ack_exit", 32'(write_finish), 32'(len == 0));
    endtask

    task automatic wait_finish(input int len, input int nbursts);
        int waited = 0;
        while (finish_cnt == 0 && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        repeat (4) @(negedge clk);
        chk_val("finish_pulses", 32'(finish_cnt), 32'd1);
        chk_val("rd_total", 32'(rd_cnt), 32'(len));
        chk_val("rd_outside_burst", 32'(rd_outside), 32'd0);
        chk_val("bursts_seen", 32'(bursts_seen), 32'(nbursts));
        chk_val("bursts_left", 32'(exp_burst.size()), 32'd0);
        chk_val("data_left", 32'(exp_data.size()), 32'd0);
    endtask

    initial begin : main
        int waited;
        repeat (3) @(negedge clk);
        chk_val("rst_ack", 32'(write_req_ack), 32'd0);
        chk_val("rst_req", 32'(wr_burst_req), 32'd0);
        chk_val("rst_len", 32'(wr_burst_len), 32'd0);
        chk_val("rst_addr", 32'(wr_burst_addr), 32'd0);
        chk_val("rst_misc", 32'({write_finish, fifo_aclr, fifo_rd_en}), 32'd0);
        #1 rst_n = 1'b1;

        // 256 words at 0, FIFO filled up front
        start_frame(24'h000000, 24'd256);
        @(posedge clk); #1; fill(256);
        wait_finish(256, 2);

        // 300 words: 128,128,44
        start_frame(24'h000000, 24'd300);
        @(posedge clk); #1; fill(300);
        wait_finish(300, 3);

        // zero length
        start_frame(24'h000040, 24'd0);
        repeat (10) @(negedge clk);
        chk_val("zero_finish", 32'(finish_cnt), 32'd1);
        chk_val("zero_bursts", 32'(bursts_seen), 32'd0);

        // FIFO threshold
        start_frame(24'h000200, 24'd256);
        @(posedge clk); #1; fill(100);
        repeat (20) @(negedge clk);
        chk_val("thr_hold_req", 32'(wr_burst_req), 32'd0);
        chk_val("thr_hold_bursts", 32'(bursts_seen), 32'd0);
        @(posedge clk); #1; fill(28);
        @(negedge clk);
        chk_val("thr_same_cycle", 32'(wr_burst_req), 32'd0);
        @(negedge clk);
        chk_val("thr_next_cycle", 32'(wr_burst_req), 32'd1);
        @(posedge clk); #1; fill(128);
        wait_finish(256, 2);

        // address wrap
        start_frame(24'hFFFF80, 24'd256);
        @(posedge clk); #1; fill(256);
        wait_finish(256, 2);

        // reset during second burst
        start_frame(24'h000000, 24'd256);
        @(posedge clk); #1; fill(256);
        waited = 0;
        while (bursts_seen < 2 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk_val("reached_burst2", 32'(bursts_seen), 32'd2);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_val("mid_rst_ack", 32'(write_req_ack), 32'd0);
        chk_val("mid_rst_req", 32'(wr_burst_req), 32'd0);
        chk_val("mid_rst_len", 32'(wr_burst_len), 32'd0);
        chk_val("mid_rst_addr", 32'(wr_burst_addr), 32'd0);
        chk_val("mid_rst_misc", 32'({write_finish, fifo_aclr, fifo_rd_en}), 32'd0);
        fifo_q.delete();
        exp_data.delete();
        exp_burst.delete();
        fifo_rd_data_count = '0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        start_frame(24'h001000, 24'd300);
        @(posedge clk); #1; fill(300);
        wait_finish(300, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
